// File: rtl/arbitro_detector_if.sv
// Requester-side bus of arbitro_detector: two word requesters and the shared response.
// Handshake: a word moves when reqN_valid and reqN_ready are high in the same cycle; valid must hold until then.
interface arbitro_detector_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
);
  logic          req0_valid;
  logic [W-1:0]  req0_dato;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_dato;
  logic          req1_ready;
  logic          resp_valid;
  logic          resp_id;
  logic [CW-1:0] resp_cuenta1;
  logic [CW-1:0] resp_cuenta2;

  modport master (
    output req0_valid, req0_dato, req1_valid, req1_dato,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_cuenta1, resp_cuenta2
  );

  modport slave (
    input  req0_valid, req0_dato, req1_valid, req1_dato,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_cuenta1, resp_cuenta2
  );
endinterface

// File: rtl/arbitro_detector.sv
// Round-robin front end sharing one detector_secuencia between two requesters; counts led1/led2 per word.
// Optional macro SERIE_LSB_PRIMERO_EN: serialize LSB first instead of MSB first.
module arbitro_detector #(
  parameter int W       = 8,
  parameter int DET_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  arbitro_detector_if.slave   bus,
  output logic                det_reset,
  output logic                det_entrada,
  input  logic                det_led1,
  input  logic                det_led2,
  output logic [2:0]          dbg_estado
);
  localparam int CW = $clog2(W + 1);
  localparam int NW = $clog2(W + DET_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } estado_t;

  estado_t       estado, estado_sig;
  logic [NW-1:0] paso;
  logic [W-1:0]  palabra;
  logic          id_act;
  logic          ultimo;
  logic [CW-1:0] cuenta1, cuenta2, cuenta1_sig, cuenta2_sig;
  logic          muestra;
  logic          gana0, gana1, acepta;

  // ultimo holds the id granted last; on a tie the other requester wins.
  assign gana0  = bus.req0_valid & (~bus.req1_valid | ultimo);
  assign gana1  = bus.req1_valid & (~bus.req0_valid | ~ultimo);
  assign bus.req0_ready = (estado == IDLE) & gana0;
  assign bus.req1_ready = (estado == IDLE) & gana1;
  assign acepta = bus.req0_ready | bus.req1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE:    if (acepta) estado_sig = CLR;
      CLR:     estado_sig = SHIFT;
      SHIFT:   if (paso == NW'(W - 1)) estado_sig = (DET_LAT == 0) ? RESP : DRAIN;
      DRAIN:   if (paso == NW'(DET_LAT - 1)) estado_sig = RESP;
      RESP:    estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  assign dbg_estado = estado;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     paso <= '0;
    else if (estado_sig != estado) paso <= '0;
    else if (estado == SHIFT || estado == DRAIN) paso <= paso + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      palabra <= '0;
      id_act  <= 1'b0;
      ultimo  <= 1'b1;
    end else if (acepta) begin
      palabra <= gana0 ? bus.req0_dato : bus.req1_dato;
      id_act  <= gana1;
      ultimo  <= gana1;
    end else if (estado == SHIFT) begin
`ifdef SERIE_LSB_PRIMERO_EN
      palabra <= {1'b0, palabra[W-1:1]};
`else
      palabra <= {palabra[W-2:0], 1'b0};
`endif
    end
  end

`ifdef SERIE_LSB_PRIMERO_EN
  assign det_entrada = (estado == SHIFT) & palabra[0];
`else
  assign det_entrada = (estado == SHIFT) & palabra[W-1];
`endif

  assign det_reset = reset | (estado == CLR);

  // muestra marks the cycles whose detector outputs belong to bits of the current word.
  generate
    if (DET_LAT == 0) begin : g_mealy
      assign muestra = (estado == SHIFT);
    end else begin : g_reg
      logic [DET_LAT-1:0] tubo;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) tubo <= '0;
        else       tubo <= (tubo << 1) | DET_LAT'(estado == SHIFT);
      end
      assign muestra = tubo[DET_LAT-1];
    end
  endgenerate

  assign cuenta1_sig = cuenta1 + CW'(muestra & det_led1);
  assign cuenta2_sig = cuenta2 + CW'(muestra & det_led2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta1 <= '0;
      cuenta2 <= '0;
    end else if (estado == CLR) begin
      cuenta1 <= '0;
      cuenta2 <= '0;
    end else begin
      cuenta1 <= cuenta1_sig;
      cuenta2 <= cuenta2_sig;
    end
  end

  // Response fields include the final sample and then hold until the next word finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resp_id      <= 1'b0;
      bus.resp_cuenta1 <= '0;
      bus.resp_cuenta2 <= '0;
    end else if (estado_sig == RESP && estado != RESP) begin
      bus.resp_id      <= id_act;
      bus.resp_cuenta1 <= cuenta1_sig;
      bus.resp_cuenta2 <= cuenta2_sig;
    end
  end

  assign bus.resp_valid = (estado == RESP);
endmodule

// File: tb/tb_arbitro_detector.sv
// Bench for arbitro_detector with a registered "101"/"110" detector stub and a cycle-level reference model.
module tb_arbitro_detector;
  localparam int W       = 8;
  localparam int DET_LAT = 1;
  localparam int CW      = $clog2(W + 1);
  localparam int RW      = 1 + 2 * CW;

  logic clk = 1'b0;
  logic reset;
  logic det_reset, det_entrada, det_led1, det_led2;
  logic [2:0] dbg_estado;
  logic inj1;
  logic [2:0] hist;
  logic stub1, stub2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  arbitro_detector_if #(.W(W)) bus ();

  arbitro_detector #(.W(W), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .det_reset(det_reset), .det_entrada(det_entrada),
    .det_led1(det_led1), .det_led2(det_led2), .dbg_estado(dbg_estado)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered detector stub, history cleared by det_reset
  always @(posedge clk) begin
    if (det_reset) begin
      hist  <= 3'b000;
      stub1 <= 1'b0;
      stub2 <= 1'b0;
    end else begin
      hist  <= {hist[1:0], det_entrada};
      stub1 <= ({hist[1:0], det_entrada} == 3'b101);
      stub2 <= ({hist[1:0], det_entrada} == 3'b110);
    end
  end
  assign det_led1 = stub1 | inj1;
  assign det_led2 = stub2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic bit_at(input logic [W-1:0] w, input int k);
`ifdef SERIE_LSB_PRIMERO_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  function automatic int count_pat(input logic [W-1:0] w, input logic [2:0] pat);
    logic [2:0] h;
    int n;
    h = 3'b000;
    n = 0;
    for (int k = 0; k < W; k++) begin
      h = {h[1:0], bit_at(w, k)};
      if (h == pat) n++;
    end
    return n;
  endfunction

  logic [RW-1:0] exp_q[$];
  int            due_q[$];
  int            acc_cyc  = -1000;
  int            free_cyc = 0;
  logic [W-1:0]  acc_word = '0;
  logic          m_last   = 1'b1;
  logic [RW-1:0] held     = '0;

  always @(negedge clk) begin
    logic e0, e1, v0, v1, exp_in, exp_rv;
    logic [W-1:0] w;
    int k;
    if (reset) begin
      check("rst_req0_ready", bus.req0_ready, 0);
      check("rst_req1_ready", bus.req1_ready, 0);
      check("rst_det_reset", det_reset, 1);
      check("rst_det_entrada", det_entrada, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_fields", {bus.resp_id, bus.resp_cuenta1, bus.resp_cuenta2}, 0);
      exp_q.delete();
      due_q.delete();
      acc_cyc  = -1000;
      free_cyc = 0;
      m_last   = 1'b1;
      held     = '0;
    end else begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      e0 = (cyc >= free_cyc) && v0 && (!v1 || m_last);
      e1 = (cyc >= free_cyc) && v1 && (!v0 || !m_last);
      check("req0_ready", bus.req0_ready, e0);
      check("req1_ready", bus.req1_ready, e1);
      check("det_reset", det_reset, cyc == acc_cyc + 1);
      k = cyc - acc_cyc - 2;
      exp_in = (k >= 0 && k < W) ? bit_at(acc_word, k) : 1'b0;
      check("det_entrada", det_entrada, exp_in);
      exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
      check("resp_valid", bus.resp_valid, exp_rv);
      if (exp_rv) begin
        held = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      check("resp_fields", {bus.resp_id, bus.resp_cuenta1, bus.resp_cuenta2}, held);
      if (e0 || e1) begin
        w        = e0 ? bus.req0_dato : bus.req1_dato;
        acc_cyc  = cyc;
        acc_word = w;
        m_last   = e1;
        free_cyc = cyc + W + 3 + DET_LAT;
        exp_q.push_back({e1, CW'(count_pat(w, 3'b101)), CW'(count_pat(w, 3'b110))});
        due_q.push_back(cyc + W + 2 + DET_LAT);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [W-1:0] w);
    if (id == 0) begin bus.req0_valid = v; bus.req0_dato = w; end
    else         begin bus.req1_valid = v; bus.req1_dato = w; end
  endtask

  task automatic send(input int id, input logic [W-1:0] w, input bit inject, input bit abort);
    bit ok;
    ok = 0;
    set_req(id, 1'b1, w);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (id == 0 ? bus.req0_ready : bus.req1_ready) ok = 1;
    end
    check("accept_timeout", ok, 1);
    tick();
    set_req(id, 1'b0, '0);
    if (abort) begin
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      check("abort_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("abort_entrada", det_entrada, 0);
      check("abort_det_reset", det_reset, 1);
      check("abort_resp", {bus.resp_valid, bus.resp_id, bus.resp_cuenta1, bus.resp_cuenta2}, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      tick();
    end else if (inject) begin
      tick();
      inj1 = 1'b1;
      tick();
      inj1 = 1'b0;
      repeat (W) tick();
      inj1 = 1'b1;
      tick();
      inj1 = 1'b0;
      repeat (2) tick();
    end else begin
      repeat (W + 4) tick();
    end
  endtask

  task automatic both(input logic [W-1:0] w0, input logic [W-1:0] w1, input int n_acc);
    int n;
    n = 0;
    set_req(0, 1'b1, w0);
    set_req(1, 1'b1, w1);
    for (int i = 0; i < 30 * n_acc && n < n_acc; i++) begin
      @(negedge clk);
      if (n == 0) check("first_grant_req0", bus.req0_ready | bus.req1_ready ? bus.req0_ready : 1'b1, 1);
      if (bus.req0_ready || bus.req1_ready) n++;
    end
    check("both_accepts", n, n_acc);
    tick();
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (W + 4) tick();
  endtask

  task automatic random_phase(input int n_cyc);
    logic a0, a1;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      tick();
      if (a0) set_req(0, 1'b0, '0);
      else if (!bus.req0_valid && $urandom_range(0, 3) == 0) set_req(0, 1'b1, W'($urandom));
      if (a1) set_req(1, 1'b0, '0);
      else if (!bus.req1_valid && $urandom_range(0, 3) == 0) set_req(1, 1'b1, W'($urandom));
    end
    @(negedge clk);
    a0 = bus.req0_valid & bus.req0_ready;
    a1 = bus.req1_valid & bus.req1_ready;
    tick();
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (2 * W + 8) tick();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inj1  = 1'b0;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    send(0, 8'hAA, 0, 0);
    send(1, 8'hDB, 0, 0);
    send(1, 8'h03, 0, 0);
    both(8'hFF, 8'hAA, 4);
    send(0, 8'hB6, 0, 1);
    both(8'h5A, 8'hC3, 2);
    send(1, 8'h00, 1, 0);
    send(0, 8'hAD, 1, 0);
    random_phase(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
